// File: rtl/spi_bus_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the shared spi_master.
// The slave modport is the arbiter's view; the master modport is the surrounding logic.
interface spi_bus_arbiter_if #(
  parameter int DATA_W = 16
);
  logic              a_enable;
  logic [DATA_W-1:0] a_tx_data;
  logic              a_busy;
  logic              a_done;
  logic [DATA_W-1:0] a_rx_data;
  logic              b_enable;
  logic [DATA_W-1:0] b_tx_data;
  logic              b_busy;
  logic              b_done;
  logic [DATA_W-1:0] b_rx_data;
  logic              m_enable;
  logic              m_rst_n;
  logic [DATA_W-1:0] m_tx_data;
  logic              m_busy;
  logic [DATA_W-1:0] m_rx_data;
  logic [1:0]        grant;
  logic              timeout_err;

  modport slave (
    input  a_enable, a_tx_data, b_enable, b_tx_data, m_busy, m_rx_data,
    output a_busy, a_done, a_rx_data, b_busy, b_done, b_rx_data,
    output m_enable, m_rst_n, m_tx_data, grant, timeout_err
  );

  modport master (
    output a_enable, a_tx_data, b_enable, b_tx_data, m_busy, m_rx_data,
    input  a_busy, a_done, a_rx_data, b_busy, b_done, b_rx_data,
    input  m_enable, m_rst_n, m_tx_data, grant, timeout_err
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one spi_master between requesters A and B,
// with a guard gap between transfers and a timeout abort for a stalled master.
module spi_bus_arbiter #(
  parameter int DATA_W         = 16,
  parameter int GUARD_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  spi_bus_arbiter_if.slave  bus
);

  localparam int GW = $clog2(GUARD_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [GW-1:0] GUARD_LAST   = GW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_POR       = 3'd0,
    ST_IDLE      = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_ABORT     = 3'd4,
    ST_GUARD     = 3'd5
  } state_t;

  localparam state_t AFTER_XFER = (GUARD_CYCLES == 0) ? ST_IDLE : ST_GUARD;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;           // 0 = A, 1 = B
  logic              last_served_q, last_served_d;
  logic              pend_a_q, pend_a_d;
  logic              pend_b_q, pend_b_d;
  logic [DATA_W-1:0] cap_a_q, cap_a_d;
  logic [DATA_W-1:0] cap_b_q, cap_b_d;
  logic [DATA_W-1:0] a_rx_q, a_rx_d;
  logic [DATA_W-1:0] b_rx_q, b_rx_d;
  logic              a_done_q, a_done_d;
  logic              b_done_q, b_done_d;
  logic [1:0]        grant_q, grant_d;
  logic              m_enable_q, m_enable_d;
  logic              m_rst_n_q, m_rst_n_d;
  logic [DATA_W-1:0] m_tx_q, m_tx_d;
  logic [TW-1:0]     tout_cnt_q, tout_cnt_d;
  logic [GW-1:0]     guard_cnt_q, guard_cnt_d;
  logic              timeout_err_q, timeout_err_d;
  logic              accept_a_s, accept_b_s, pick_b_s;

  // Requests are blocked during the done pulse so the next one lands a cycle later.
  assign accept_a_s = bus.a_enable && !pend_a_q && !a_done_q;
  assign accept_b_s = bus.b_enable && !pend_b_q && !b_done_q;

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_served_d = last_served_q;
    pend_a_d      = pend_a_q | accept_a_s;
    pend_b_d      = pend_b_q | accept_b_s;
    cap_a_d       = accept_a_s ? bus.a_tx_data : cap_a_q;
    cap_b_d       = accept_b_s ? bus.b_tx_data : cap_b_q;
    a_rx_d        = a_rx_q;
    b_rx_d        = b_rx_q;
    a_done_d      = 1'b0;
    b_done_d      = 1'b0;
    grant_d       = grant_q;
    m_tx_d        = m_tx_q;
    tout_cnt_d    = tout_cnt_q;
    guard_cnt_d   = guard_cnt_q;
    timeout_err_d = 1'b0;
    pick_b_s      = pend_b_q && (!pend_a_q || (last_served_q == 1'b0));

    case (state_q)
      ST_POR: begin
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (pend_a_q || pend_b_q) begin
          owner_d    = pick_b_s;
          grant_d    = pick_b_s ? 2'b10 : 2'b01;
          m_tx_d     = pick_b_s ? cap_b_q : cap_a_q;
          tout_cnt_d = '0;
          state_d    = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.m_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (tout_cnt_q == TIMEOUT_LAST) begin
          // Done and pend clear land together so busy drops in the done cycle.
          state_d       = ST_ABORT;
          timeout_err_d = 1'b1;
          a_done_d      = !owner_q;
          b_done_d      = owner_q;
          pend_a_d      = owner_q ? pend_a_d : 1'b0;
          pend_b_d      = owner_q ? 1'b0 : pend_b_d;
        end else begin
          tout_cnt_d = tout_cnt_q + TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.m_busy) begin
          a_rx_d        = owner_q ? a_rx_q : bus.m_rx_data;
          b_rx_d        = owner_q ? bus.m_rx_data : b_rx_q;
          a_done_d      = !owner_q;
          b_done_d      = owner_q;
          pend_a_d      = owner_q ? pend_a_d : 1'b0;
          pend_b_d      = owner_q ? 1'b0 : pend_b_d;
          last_served_d = owner_q;
          grant_d       = 2'b00;
          guard_cnt_d   = '0;
          state_d       = AFTER_XFER;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_ABORT: begin
        last_served_d = owner_q;
        grant_d       = 2'b00;
        guard_cnt_d   = '0;
        state_d       = AFTER_XFER;
      end
      ST_GUARD: begin
        if (guard_cnt_q == GUARD_LAST) begin
          state_d = ST_IDLE;
        end else begin
          guard_cnt_d = guard_cnt_q + GW'(1);
        end
      end
      default: begin
        state_d = ST_POR;
      end
    endcase

    m_enable_d = (state_d == ST_ISSUE);
    m_rst_n_d  = !((state_d == ST_POR) || (state_d == ST_ABORT));
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_POR;
      owner_q       <= 1'b0;
      last_served_q <= 1'b1;
      pend_a_q      <= 1'b0;
      pend_b_q      <= 1'b0;
      cap_a_q       <= '0;
      cap_b_q       <= '0;
      a_rx_q        <= '0;
      b_rx_q        <= '0;
      a_done_q      <= 1'b0;
      b_done_q      <= 1'b0;
      grant_q       <= 2'b00;
      m_enable_q    <= 1'b0;
      m_rst_n_q     <= 1'b0;
      m_tx_q        <= '0;
      tout_cnt_q    <= '0;
      guard_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_served_q <= last_served_d;
      pend_a_q      <= pend_a_d;
      pend_b_q      <= pend_b_d;
      cap_a_q       <= cap_a_d;
      cap_b_q       <= cap_b_d;
      a_rx_q        <= a_rx_d;
      b_rx_q        <= b_rx_d;
      a_done_q      <= a_done_d;
      b_done_q      <= b_done_d;
      grant_q       <= grant_d;
      m_enable_q    <= m_enable_d;
      m_rst_n_q     <= m_rst_n_d;
      m_tx_q        <= m_tx_d;
      tout_cnt_q    <= tout_cnt_d;
      guard_cnt_q   <= guard_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.a_busy      = pend_a_q;
  assign bus.b_busy      = pend_b_q;
  assign bus.a_done      = a_done_q;
  assign bus.b_done      = b_done_q;
  assign bus.a_rx_data   = a_rx_q;
  assign bus.b_rx_data   = b_rx_q;
  assign bus.grant       = grant_q;
  assign bus.m_enable    = m_enable_q;
  assign bus.m_rst_n     = m_rst_n_q;
  assign bus.m_tx_data   = m_tx_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
